// File: rtl/replica_pkg.sv
// Shared replica-ring types: node count, total-distance word, and dump sequencer states.
package replica_pkg;

    localparam int unsigned node_num = 4;
    localparam int unsigned TOTAL_W  = 16;

    typedef logic [TOTAL_W-1:0] total_data_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RUN,
        SHIFT,
        DRAIN
    } dump_state_t;

endpackage

// File: rtl/dump_fifo.sv
// Small synchronous FIFO holding packed {index, distance} dump entries.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module dump_fifo #(
    parameter int unsigned W     = 18,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [W-1:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/distance_dump_seq.sv
// Non-destructive ring distance dump: shares the ring shift port with the host, recirculates
// every value read, streams (index, distance) entries out and publishes the dump minimum.
module distance_dump_seq
    import replica_pkg::*;
#(
    parameter int unsigned NODES = node_num,
    parameter int unsigned IDX_W = $clog2(NODES),
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              running,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_done,
    input  logic              host_shift,
    input  total_data_t       host_wdata,
    output logic              distance_shift,
    output total_data_t       distance_wdata,
    input  total_data_t       distance_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output total_data_t       out_data,
    output total_data_t       min_data,
    output logic [IDX_W-1:0]  min_index
);

    localparam int unsigned ENT_W = IDX_W + TOTAL_W;

    dump_state_t       state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    total_data_t       run_min_q, run_min_d;
    logic [IDX_W-1:0]  run_idx_q, run_idx_d;
    total_data_t       min_data_q, min_data_d;
    logic [IDX_W-1:0]  min_index_q, min_index_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_rdata;
    logic [IDX_W-1:0]  push_idx;

    // Ring order leaves the last node first, so the k-th read belongs to replica NODES-1-k.
    assign push_idx = IDX_W'(NODES - 1) - cnt_q;
    assign fifo_pop = !fifo_empty && out_ready;

    dump_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({push_idx, distance_rdata}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_index = fifo_rdata[ENT_W-1:TOTAL_W];
    assign out_data  = fifo_rdata[TOTAL_W-1:0];
    assign dump_busy = (state_q != IDLE);
    assign min_data  = min_data_q;
    assign min_index = min_index_q;

    // Next-state, shift-port mux and minimum tracking.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_min_d      = run_min_q;
        run_idx_d      = run_idx_q;
        min_data_d     = min_data_q;
        min_index_d    = min_index_q;
        fifo_push      = 1'b0;
        distance_shift = 1'b0;
        distance_wdata = '0;
        dump_done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (host_shift) begin
                    distance_shift = 1'b1;
                    distance_wdata = host_wdata;
                end
                if (dump_start) begin
                    state_d = WAIT_RUN;
                    cnt_d   = '0;
                end
            end
            WAIT_RUN: begin
                if (!running) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Stall the ring on backpressure or an unexpected run; never drop a read value.
                if (!running && (!fifo_full || fifo_pop)) begin
                    distance_shift = 1'b1;
                    distance_wdata = distance_rdata;
                    fifo_push      = 1'b1;
                    if ((cnt_q == '0) || (distance_rdata < run_min_q)) begin
                        run_min_d = distance_rdata;
                        run_idx_d = push_idx;
                    end
                    if (cnt_q == IDX_W'(NODES - 1)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d     = IDLE;
                    dump_done   = 1'b1;
                    min_data_d  = run_min_q;
                    min_index_d = run_idx_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_min_q   <= '1;
            run_idx_q   <= '0;
            min_data_q  <= '1;
            min_index_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_min_q   <= run_min_d;
            run_idx_q   <= run_idx_d;
            min_data_q  <= min_data_d;
            min_index_q <= min_index_d;
        end
    end

endmodule

// File: tb/tb_distance_dump_seq.sv
// Scoreboard bench for distance_dump_seq with a behavioural 4-node shift ring.
module tb_distance_dump_seq;
    import replica_pkg::*;

    localparam int unsigned NODES = 4;
    localparam int unsigned IDX_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              running = 1'b0;
    logic              dump_start = 1'b0;
    logic              dump_busy;
    logic              dump_done;
    logic              host_shift = 1'b0;
    total_data_t       host_wdata = '0;
    logic              distance_shift;
    total_data_t       distance_wdata;
    total_data_t       distance_rdata;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [IDX_W-1:0]  out_index;
    total_data_t       out_data;
    total_data_t       min_data;
    logic [IDX_W-1:0]  min_index;

    always #5 clk = ~clk;

    distance_dump_seq #(.NODES(NODES), .IDX_W(IDX_W), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .running        (running),
        .dump_start     (dump_start),
        .dump_busy      (dump_busy),
        .dump_done      (dump_done),
        .host_shift     (host_shift),
        .host_wdata     (host_wdata),
        .distance_shift (distance_shift),
        .distance_wdata (distance_wdata),
        .distance_rdata (distance_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_index      (out_index),
        .out_data       (out_data),
        .min_data       (min_data),
        .min_index      (min_index)
    );

    // Ring model: node 0 takes the written word, last node drives read data.
    total_data_t ring [NODES];
    total_data_t ring_init [NODES];
    logic        ring_load = 1'b0;
    int          shift_total = 0;

    always @(posedge clk) begin
        if (ring_load) begin
            for (int i = 0; i < int'(NODES); i++) ring[i] <= ring_init[i];
        end else if (distance_shift) begin
            ring[0] <= distance_wdata;
            for (int i = 1; i < int'(NODES); i++) ring[i] <= ring[i-1];
            shift_total <= shift_total + 1;
        end
    end

    assign distance_rdata = ring[NODES-1];

    typedef struct {
        logic [IDX_W-1:0] idx;
        total_data_t      data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic load_ring(input total_data_t a, input total_data_t b,
                             input total_data_t c, input total_data_t d);
        @(posedge clk); #1;
        ring_init = '{a, b, c, d};
        ring_load = 1'b1;
        @(posedge clk); #1;
        ring_load = 1'b0;
    endtask

    task automatic start_dump();
        exp_t e;
        for (int i = int'(NODES) - 1; i >= 0; i--) begin
            e.idx  = IDX_W'(i);
            e.data = ring_init[i];
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dump_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_after(input string name, input int base,
                               input total_data_t req_min, input logic [IDX_W-1:0] req_idx);
        @(negedge clk);
        check({name, "_min_data"}, 32'(min_data), 32'(req_min));
        check({name, "_min_index"}, 32'(min_index), 32'(req_idx));
        check({name, "_shifts"}, 32'(shift_total - base), NODES);
        check({name, "_busy"}, 32'(dump_busy), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < int'(NODES); i++) begin
            check({name, "_ring"}, 32'(ring[i]), 32'(ring_init[i]));
        end
    endtask

    initial begin
        int base;

        // Monitor: compares every accepted entry against the scoreboard queue.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!reset && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_entry: got idx %0d data 0x%0h, expected none",
                                 out_index, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("entry_index", 32'(out_index), 32'(e.idx));
                        check("entry_data", 32'(out_data), 32'(e.data));
                    end
                end
            end
        join_none

        @(negedge clk);
        check("rst_min_data", 32'(min_data), 32'hFFFF);
        check("rst_min_index", 32'(min_index), 32'd0);
        check("rst_busy", 32'(dump_busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_shift", 32'(distance_shift), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic dump, host always ready.
        load_ring(16'd100, 16'd50, 16'd75, 16'd200);
        base = shift_total;
        start_dump();
        wait_done("basic");
        check_after("basic", base, 16'd50, 2'd1);

        // Backpressure: host not ready for 6 cycles after start.
        out_ready = 1'b0;
        base = shift_total;
        start_dump();
        repeat (5) @(posedge clk);
        #1;
        check("bp_shifts_stalled", 32'(shift_total - base), 32'd2);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_head_index", 32'(out_index), 32'd3);
        out_ready = 1'b1;
        wait_done("bp");
        check_after("bp", base, 16'd50, 2'd1);

        // Start while the ring is running: no shifts until it stops.
        running = 1'b1;
        base = shift_total;
        start_dump();
        repeat (10) @(posedge clk);
        #1;
        check("run_no_shift", 32'(shift_total - base), 32'd0);
        check("run_busy", 32'(dump_busy), 32'd1);
        running = 1'b0;
        wait_done("run");
        check_after("run", base, 16'd50, 2'd1);

        // Direct host shift while idle is a same-cycle pass-through.
        @(posedge clk); #1;
        host_shift = 1'b1;
        host_wdata = 16'h0123;
        @(negedge clk);
        check("host_shift", 32'(distance_shift), 32'd1);
        check("host_wdata", 32'(distance_wdata), 32'h0123);
        @(posedge clk); #1;
        host_shift = 1'b0;
        check("host_ring0", 32'(ring[0]), 32'h0123);

        // Host shift held during a dump is dropped.
        load_ring(16'd100, 16'd50, 16'd75, 16'd200);
        base = shift_total;
        start_dump();
        host_shift = 1'b1;
        wait_done("hostbusy");
        host_shift = 1'b0;
        check_after("hostbusy", base, 16'd50, 2'd1);

        // Ties keep the earlier-read (higher) index.
        load_ring(16'd40, 16'd40, 16'd90, 16'd40);
        base = shift_total;
        start_dump();
        wait_done("ties");
        check_after("ties", base, 16'd40, 2'd3);

        // Extreme values.
        load_ring(16'd0, 16'hFFFF, 16'hFFFF, 16'd1);
        base = shift_total;
        start_dump();
        wait_done("extreme");
        check_after("extreme", base, 16'd0, 2'd0);

        // Reset after two shifts aborts the dump.
        load_ring(16'd100, 16'd50, 16'd75, 16'd200);
        base = shift_total;
        start_dump();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (shift_total - base >= 2) break;
        end
        check("abort_two_shifts", 32'(shift_total - base), 32'd2);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", 32'(dump_busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_shift", 32'(distance_shift), 32'd0);
        check("abort_min_data", 32'(min_data), 32'hFFFF);
        check("abort_min_index", 32'(min_index), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Clean dump after the abort.
        load_ring(16'd100, 16'd50, 16'd75, 16'd200);
        base = shift_total;
        start_dump();
        wait_done("after_abort");
        check_after("after_abort", base, 16'd50, 2'd1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
